// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares the single RAM port among REQS cache requesters.
// One grant is held per RAM transaction, and priority rotates past the winner after each completed access.
module ram_arbiter #(
  parameter  int REQS = 4,
  localparam int IW   = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [REQS-1:0]   req_ren,
  input  logic [REQS-1:0]   req_wen,
  input  logic [REQS*32-1:0] req_addr,
  input  logic [REQS*32-1:0] req_store,
  output logic [REQS-1:0]   req_wait,
  output logic [31:0]       req_load,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [31:0]       ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_error
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t          st_q, st_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            ram_error_q, ram_error_d;

  logic [REQS-1:0] req_any;
  logic            found;
  logic [IW-1:0]   winner;
  int              idx;
  logic            granted;
  logic            gnt_active;
  logic            done;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_store;

  assign req_any    = req_ren | req_wen;
  assign granted    = (st_q == GRANT);
  assign gnt_active = req_any[gnt_q];
  assign done       = granted && (ramstate == RAM_ACCESS);
  assign sel_addr   = req_addr[int'(gnt_q)*32 +: 32];
  assign sel_store  = req_store[int'(gnt_q)*32 +: 32];

  // Search for the first active requester, starting at the priority pointer and wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < REQS; k++) begin
      idx = (int'(ptr_q) + k) % REQS;
      if (!found && req_any[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    ram_error_d = ram_error_q;
    unique case (st_q)
      IDLE: begin
        if (found) begin
          gnt_d = winner;
          st_d  = GRANT;
        end
      end
      GRANT: begin
        // An ERROR response is retried: the grant is held until ACCESS arrives or the requester drops.
        if (ramstate == RAM_ERROR) ram_error_d = 1'b1;
        if (!gnt_active) begin
          st_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          st_d  = IDLE;
          ptr_d = (gnt_q == IW'(REQS - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q        <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      ram_error_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      ram_error_q <= ram_error_d;
    end
  end

  // A write wins when a requester raises both enables.
  always_comb begin
    ramWEN   = granted & req_wen[gnt_q];
    ramREN   = granted & req_ren[gnt_q] & ~req_wen[gnt_q];
    ramaddr  = granted ? sel_addr  : 32'd0;
    ramstore = granted ? sel_store : 32'd0;
    req_wait = req_any & ~(done ? (REQS'(1) << gnt_q) : REQS'(0));
  end

  assign req_load  = ramload;
  assign ram_error = ram_error_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter: reset, read latency, rotation order, write precedence, abort and error handling.
module tb_ram_arbiter;

  localparam int REQS = 4;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [REQS-1:0]   req_ren, req_wen, req_wait;
  logic [REQS*32-1:0] req_addr, req_store;
  logic [31:0]       req_load, ramaddr, ramstore, ramload;
  logic              ramREN, ramWEN, ram_error;
  logic [1:0]        ramstate;

  logic [31:0] addrTab [REQS];
  int errors = 0;
  int checks = 0;

  ram_arbiter #(.REQS(REQS)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .ram_error(ram_error)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ren, input logic [3:0] wen,
                               input logic [1:0] rstate, input logic [31:0] load);
    req_ren  = ren;
    req_wen  = wen;
    ramstate = rstate;
    ramload  = load;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    addrTab[0] = 32'h0000_1000;
    addrTab[1] = 32'h0000_0040;
    addrTab[2] = 32'h0000_2020;
    addrTab[3] = 32'h0000_0100;
    req_addr  = {addrTab[3], addrTab[2], addrTab[1], addrTab[0]};
    req_store = {32'h1234_5678, 32'h0000_2222, 32'h0000_1111, 32'h0000_0000};

    // Reset held with all requesters reading
    nRST = 1'b0;
    applyStimulus(4'b1111, 4'b0000, FREE, 32'd0);
    checkOutput("rst_ramREN", 32'(ramREN), 32'd0);
    checkOutput("rst_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("rst_wait", 32'(req_wait), 32'hF);
    checkOutput("rst_error", 32'(ram_error), 32'd0);
    checkOutput("rst_addr", ramaddr, 32'd0);
    nextCycle();
    nRST = 1'b1;
    nextCycle();
    checkOutput("first_grant_ren", 32'(ramREN), 32'd1);
    checkOutput("first_grant_addr", ramaddr, addrTab[0]);

    // Reset while granted drops the enables immediately
    nRST = 1'b0;
    #1;
    checkOutput("midrst_ramREN", 32'(ramREN), 32'd0);
    checkOutput("midrst_wait", 32'(req_wait), 32'hF);
    applyStimulus(4'b0000, 4'b0000, FREE, 32'd0);
    nextCycle();
    nRST = 1'b1;

    // Single read from requester 1 with two BUSY cycles
    applyStimulus(4'b0010, 4'b0000, FREE, 32'd0);
    checkOutput("rd_idle_ren", 32'(ramREN), 32'd0);
    checkOutput("rd_idle_wait", 32'(req_wait), 32'h2);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, BUSY, 32'd0);
    checkOutput("rd_busy1_ren", 32'(ramREN), 32'd1);
    checkOutput("rd_busy1_addr", ramaddr, 32'h40);
    checkOutput("rd_busy1_wait", 32'(req_wait), 32'h2);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, BUSY, 32'd0);
    checkOutput("rd_busy2_ren", 32'(ramREN), 32'd1);
    checkOutput("rd_busy2_wait", 32'(req_wait), 32'h2);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, ACCESS, 32'hDEAD_BEEF);
    checkOutput("rd_acc_ren", 32'(ramREN), 32'd1);
    checkOutput("rd_acc_wait", 32'(req_wait), 32'h0);
    checkOutput("rd_acc_load", req_load, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, FREE, 32'd0);
    checkOutput("rd_done_ren", 32'(ramREN), 32'd0);

    // Round-robin with all four requesting and zero-latency RAM
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    applyStimulus(4'b1111, 4'b0000, ACCESS, 32'd0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr%0d_idle_ren", k), 32'(ramREN), 32'd0);
      checkOutput($sformatf("rr%0d_idle_wait", k), 32'(req_wait), 32'hF);
      nextCycle();
      checkOutput($sformatf("rr%0d_ren", k), 32'(ramREN), 32'd1);
      checkOutput($sformatf("rr%0d_addr", k), ramaddr, addrTab[k % 4]);
      checkOutput($sformatf("rr%0d_wait", k), 32'(req_wait), 32'(4'hF & ~(4'b0001 << (k % 4))));
      nextCycle();
    end
    applyStimulus(4'b0000, 4'b0000, FREE, 32'd0);

    // Write precedence for requester 3 (pointer is 1 here)
    applyStimulus(4'b1000, 4'b1000, FREE, 32'd0);
    checkOutput("wr_idle_wen", 32'(ramWEN), 32'd0);
    nextCycle();
    applyStimulus(4'b1000, 4'b1000, ACCESS, 32'd0);
    checkOutput("wr_wen", 32'(ramWEN), 32'd1);
    checkOutput("wr_ren", 32'(ramREN), 32'd0);
    checkOutput("wr_store", ramstore, 32'h1234_5678);
    checkOutput("wr_addr", ramaddr, 32'h100);
    checkOutput("wr_wait", 32'(req_wait), 32'h0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, FREE, 32'd0);

    // Complete requester 1 to move the pointer to 2, then abort requester 2
    applyStimulus(4'b0010, 4'b0000, ACCESS, 32'd0);
    nextCycle();
    checkOutput("ab_pre_addr", ramaddr, addrTab[1]);
    nextCycle();
    applyStimulus(4'b0100, 4'b0000, BUSY, 32'd0);
    nextCycle();
    checkOutput("ab_grant_ren", 32'(ramREN), 32'd1);
    checkOutput("ab_grant_addr", ramaddr, addrTab[2]);
    applyStimulus(4'b0000, 4'b0000, BUSY, 32'd0);
    checkOutput("ab_drop_ren", 32'(ramREN), 32'd0);
    checkOutput("ab_drop_wait", 32'(req_wait), 32'h0);
    nextCycle();
    applyStimulus(4'b0101, 4'b0000, FREE, 32'd0);
    checkOutput("ab_idle_ren", 32'(ramREN), 32'd0);
    checkOutput("ab_idle_wait", 32'(req_wait), 32'h5);
    nextCycle();
    applyStimulus(4'b0101, 4'b0000, ACCESS, 32'd0);
    checkOutput("ab_ptr2_addr", ramaddr, addrTab[2]);
    checkOutput("ab_ptr2_wait", 32'(req_wait), 32'h1);
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, FREE, 32'd0);
    checkOutput("ab_idle2_ren", 32'(ramREN), 32'd0);
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, ACCESS, 32'd0);
    checkOutput("ab_req0_ren", 32'(ramREN), 32'd1);
    checkOutput("ab_req0_addr", ramaddr, addrTab[0]);
    checkOutput("ab_req0_wait", 32'(req_wait), 32'h0);
    nextCycle();

    // ERROR for one cycle, then ACCESS
    applyStimulus(4'b0010, 4'b0000, FREE, 32'd0);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, ERROR, 32'd0);
    checkOutput("err_ren", 32'(ramREN), 32'd1);
    checkOutput("err_wait", 32'(req_wait), 32'h2);
    checkOutput("err_flag_before", 32'(ram_error), 32'd0);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, ACCESS, 32'h0000_5A5A);
    checkOutput("err_flag_set", 32'(ram_error), 32'd1);
    checkOutput("err_retry_ren", 32'(ramREN), 32'd1);
    checkOutput("err_retry_addr", ramaddr, addrTab[1]);
    checkOutput("err_acc_wait", 32'(req_wait), 32'h0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, FREE, 32'd0);
    checkOutput("err_release_ren", 32'(ramREN), 32'd0);
    checkOutput("err_sticky1", 32'(ram_error), 32'd1);
    nextCycle();
    checkOutput("err_sticky2", 32'(ram_error), 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("err_cleared", 32'(ram_error), 32'd0);
    nRST = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter sharing the single RAM port among up to REQS cache requesters (per-CPU icache/dcache). Sits between the cache blocks and the RAM-facing signals of the memory controller. Holds one grant per RAM transaction and releases it when RAM reports ACCESS. Rotates priority after every completed access so no requester starves.

## Interface
- REQS, 4, number of requesters; index i is requester i (0 = icache0, 1 = dcache0, 2 = icache1, 3 = dcache1)
- IW, $clog2(REQS), grant index width (derived, not overridden)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- req_ren  in  REQS  read request per requester
- req_wen  in  REQS  write request per requester
- req_addr  in  REQS*32  word address per requester, requester i at bits [32i+31:32i]
- req_store  in  REQS*32  write data per requester, same packing
- req_wait  out  REQS  1 = requester i must hold its request
- req_load  out  32  read data, broadcast to all; valid only for the completing requester
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ram_error  out  1  sticky: RAM returned ERROR since reset

## Operation
- State: st in {IDLE, GRANT}; grant index gnt[IW-1:0]; priority pointer ptr[IW-1:0]; sticky ram_error.
- req_any[i] = req_ren[i] | req_wen[i].
- IDLE: winner = first i with req_any[i], searching ptr, ptr+1, ... wrapping mod REQS. If any: gnt <= winner, st <= GRANT. Else stay IDLE.
- GRANT: drive RAM from requester gnt. ramWEN = req_wen[gnt]; ramREN = req_ren[gnt] & ~req_wen[gnt] (write wins when both set); ramaddr/ramstore = requester gnt's fields.
- GRANT, ramstate == ACCESS and req_any[gnt]: access completes; ptr <= gnt+1 mod REQS; st <= IDLE.
- GRANT, req_any[gnt] == 0 (requester aborted): st <= IDLE, ptr unchanged; RAM enables low that cycle.
- GRANT, ramstate == ERROR: ram_error <= 1; access treated as not complete (stay GRANT, retry).
- GRANT, FREE or BUSY: stay GRANT.
- req_wait[i] = req_any[i] & ~(st == GRANT & gnt == i & ramstate == ACCESS). Requesters not asserting a request see req_wait 0.
- req_load = ramload at all times.
- In IDLE: ramREN = ramWEN = 0, ramaddr = ramstore = 0.
- ram_error cleared only by reset.

## Timing
- Reset (async assert): st = IDLE, gnt = 0, ptr = 0, ram_error = 0; hence ramREN = ramWEN = 0, ramaddr = ramstore = 0, req_wait = req_any (combinational).
- Reset mid-GRANT: RAM enables drop immediately; in-flight access abandoned; ptr back to 0.
- Arbitration latency: request visible in cycle n -> RAM enables high from cycle n+1.
- With ACCESS returned same cycle (zero-latency RAM): completion in cycle n+1, req_wait low only in n+1; minimum 2 cycles per access; a requester's next request is arbitrated in cycle n+2.
- Grant never changes while st == GRANT, whatever other requests do.
- Requester must hold addr/store/enables stable while req_wait = 1.
- Simultaneous requests from all REQS requesters with ptr = p: served in order p, p+1, ..., wrapping.

## Test plan
- Reset: nRST low with req_ren = 4'b1111 -> ramREN = 0, ramWEN = 0, req_wait = 4'b1111, ram_error = 0; after release, first grant goes to requester 0.
- Single read: req_ren[1] = 1, addr 0x0000_0040, RAM returns ACCESS after 2 BUSY cycles with ramload 0xDEAD_BEEF -> ramREN high 3 cycles at addr 0x40, req_wait[1] low exactly in the ACCESS cycle, req_load = 0xDEAD_BEEF.
- Round-robin: all four request continuously, zero-latency RAM -> completions in order 0,1,2,3,0 one every 2 cycles; no requester served twice before the others.
- Write precedence: req_ren[3] = req_wen[3] = 1, store 0x1234_5678 at 0x100 -> ramWEN = 1, ramREN = 0, ramstore = 0x1234_5678.
- Abort: grant to requester 2, drop req_ren[2] while ramstate = BUSY -> next cycle IDLE, ptr still 2; requester 0 then granted.
- Error: ramstate = ERROR for 1 cycle then ACCESS -> ram_error set and stays 1; access completes on ACCESS cycle, grant released.
